dram_access: RTL and testbench
==============================

# dram_access

Data-memory access unit sitting between the execute stage and the data bus (dbus). It consumes the memory-side control signals produced by instruction decode (`dram_sel`, `ram_we`) plus the ALU-computed address and the rs2 store value. It issues one sized, byte-strobed dbus transaction per access and returns a sign- or zero-extended 64-bit load result with a one-cycle `done` pulse. Misaligned accesses are detected locally and never reach the bus.

## Interface
- `XLEN`, 64: data and address width.
- `DSEL_W`, 4: width of `dram_sel`. Codes are decided as: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD, 8 SB, 9 SH, 10 SW, 11 SD. Codes 12–15 are illegal.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low. 0 = reset.
- `start` in 1: request a memory access this cycle; sampled only in IDLE.
- `ram_we` in 1: 1 = store, 0 = load. Must match the `dram_sel` class.
- `dram_sel` in DSEL_W: access kind, encoded as above.
- `addr` in XLEN: byte address.
- `wdata` in XLEN: store value, right-aligned (rs2).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `misalign` out 1: valid with `done`; 1 = access suppressed as misaligned or illegal.
- `rdata` out XLEN: extended load result. Updated on `done`, held until the next `done`.
- `req_valid` out 1: dbus request valid.
- `req_addr` out XLEN: dbus address.
- `req_size` out 3: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B.
- `req_strobe` out 8: byte write enables. All zero for loads.
- `req_data` out XLEN: lane-aligned store data.
- `resp_addr_ok` in 1: bus accepted the request.
- `resp_data_ok` in 1: bus completed the transaction; `resp_data` is valid.
- `resp_data` in XLEN: full 64-bit doubleword read from the bus.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE with `start`=1: latch `addr`, `wdata`, `dram_sel`, `ram_we`, then evaluate the access.
  - Code 0, code ≥ 12, a `ram_we` mismatch, or misalignment (halfword with addr[0]≠0, word with addr[1:0]≠0, doubleword with addr[2:0]≠0) sends the FSM to DONE with `misalign`=1.
  - Otherwise the FSM goes to REQ.
- IDLE with `start`=0: stay in IDLE.
- REQ: `req_valid`=1. All req_* outputs are stable for as long as `req_valid` is high.
  - `resp_addr_ok`=1 and `resp_data_ok`=1 in the same cycle: go to DONE.
  - `resp_addr_ok`=1 alone: go to WAIT.
  - Neither: stay in REQ.
- WAIT: `req_valid`=0. `resp_data_ok`=1 goes to DONE; otherwise stay.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Loads capture `rdata` on the `resp_data_ok` edge.
  - Shift `resp_data` right by `addr[2:0]*8`.
  - Take the low 8/16/32/64 bits.
  - LB, LH, LW sign-extend; LBU, LHU, LWU zero-extend.
- Stores drive the following request fields:
  - `req_data` = `wdata` shifted left by `addr[2:0]*8`.
  - `req_strobe` = (0x01, 0x03, 0x0F, 0xFF for SB/SH/SW/SD) shifted left by `addr[2:0]`.
  - Store completion leaves `rdata` unchanged.
- `req_addr` = latched `addr` unmodified; `req_size` follows from the access width.
- `start` while `busy`=1 is ignored; it is not queued.
- `resp_addr_ok` and `resp_data_ok` arriving in IDLE or DONE are ignored.
- Reset asserted in any state:
  - FSM goes to IDLE immediately (asynchronously).
  - All outputs drop to their reset values within the same cycle.
  - The in-flight transaction is abandoned.

## Timing
- Reset values: `busy`=0, `done`=0, `misalign`=0, `rdata`=0, `req_valid`=0, `req_addr`=0, `req_size`=0, `req_strobe`=0, `req_data`=0.
- All outputs are registered or decoded from state. There is no combinational path from the `resp_*` inputs to `req_valid`.
- `start` accepted at edge N gives `req_valid`=1 from cycle N+1.
- Minimum latency, with `addr_ok` and `data_ok` both high in cycle N+1:
  - DONE in cycle N+2.
  - `done` high in cycle N+2; `busy` low from N+3.
  - The next `start` is accepted at the end of N+3.
- Misaligned access: `done` with `misalign`=1 in cycle N+1; `req_valid` is never asserted.
- `busy` is high from cycle N+1 through the DONE cycle inclusive.

## Test plan
- LB, `addr`=0x1003, `resp_data`=0x0000_0000_8000_0000, `addr_ok` and `data_ok` both in cycle 1 → `req_size`=0, `req_strobe`=0x00, `done` in cycle 2, `rdata`=0xFFFF_FFFF_FFFF_FF80. Repeat with LBU → `rdata`=0x80.
- SH, `addr`=0x2006, `wdata`=0xABCD_1234 → `req_size`=1, `req_strobe`=0xC0, `req_data`[63:48]=0x1234, `done` with `misalign`=0, `rdata` unchanged.
- LW, `addr`=0x3002 → `req_valid` stays 0, `done`=1 and `misalign`=1 in cycle 1, `busy` low in cycle 2.
- LD, `addr`=0x4000, `addr_ok` delayed 3 cycles, `data_ok` 2 cycles after that → `req_valid` held 3 cycles with constant fields, WAIT for 2 cycles, `done` one cycle after `data_ok`, `rdata`=`resp_data`.
- `reset`=0 asserted mid-WAIT → same-cycle `busy`=0, `req_valid`=0, `rdata`=0. A later `data_ok` is ignored and `done` is never pulsed.
- `start` pulsed while in REQ → no second request. Exactly one `done` for the first access, and `misalign`=0.

Source files
------------

// File: rtl/dram_access_if.sv
// Data-bus port bundle between the memory access unit (master) and the dbus (slave).
interface dram_access_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic [2:0]      req_size;
  logic [7:0]      req_strobe;
  logic [XLEN-1:0] req_data;
  logic            resp_addr_ok;
  logic            resp_data_ok;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data
  );
endinterface

// File: rtl/dram_access.sv
// Data-memory access unit: one sized, byte-strobed dbus transaction per load/store,
// extended load result, local detection of misaligned or illegal accesses.
module dram_access #(
  parameter int XLEN   = 64,
  parameter int DSEL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ram_we,
  input  logic [DSEL_W-1:0] dram_sel,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic [XLEN-1:0]   rdata,
  dram_access_if.master     bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state;
  logic   ld_q, sx_q;

  logic       is_ld, is_st, sx, aligned, ok;
  logic [1:0] sz;
  logic [7:0] strb_base;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sx    = 1'b0;
    sz    = 2'd0;
    if (dram_sel >= DSEL_W'(1) && dram_sel <= DSEL_W'(7)) begin
      is_ld = 1'b1;
      sz    = 2'((dram_sel - DSEL_W'(1)) >> 1);
      sx    = dram_sel[0];
    end else if (dram_sel >= DSEL_W'(8) && dram_sel <= DSEL_W'(11)) begin
      is_st = 1'b1;
      sz    = 2'(dram_sel - DSEL_W'(8));
    end
    case (sz)
      2'd0:    begin aligned = 1'b1;              strb_base = 8'h01; end
      2'd1:    begin aligned = ~addr[0];          strb_base = 8'h03; end
      2'd2:    begin aligned = (addr[1:0] == 2'd0); strb_base = 8'h0F; end
      default: begin aligned = (addr[2:0] == 3'd0); strb_base = 8'hFF; end
    endcase
    ok = ((is_ld & ~ram_we) | (is_st & ram_we)) & aligned;
  end

  // The latched address offset and size drive both the bus fields and load extraction.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d, input logic [2:0] off,
                                               input logic [2:0] size, input logic sgn);
    logic [XLEN-1:0] s;
    s = d >> {off, 3'b000};
    case (size)
      3'd0:    return sgn ? {{(XLEN-8){s[7]}},   s[7:0]}  : {{(XLEN-8){1'b0}},  s[7:0]};
      3'd1:    return sgn ? {{(XLEN-16){s[15]}}, s[15:0]} : {{(XLEN-16){1'b0}}, s[15:0]};
      3'd2:    return sgn ? {{(XLEN-32){s[31]}}, s[31:0]} : {{(XLEN-32){1'b0}}, s[31:0]};
      default: return s;
    endcase
  endfunction

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign bus.req_valid = (state == REQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      misalign       <= 1'b0;
      rdata          <= '0;
      ld_q           <= 1'b0;
      sx_q           <= 1'b0;
      bus.req_addr   <= '0;
      bus.req_size   <= 3'd0;
      bus.req_strobe <= 8'h00;
      bus.req_data   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          misalign <= ~ok;
          if (ok) begin
            state          <= REQ;
            ld_q           <= is_ld;
            sx_q           <= sx;
            bus.req_addr   <= addr;
            bus.req_size   <= {1'b0, sz};
            bus.req_strobe <= is_st ? (strb_base << addr[2:0]) : 8'h00;
            bus.req_data   <= is_st ? (wdata << {addr[2:0], 3'b000}) : '0;
          end else begin
            state <= DONE;
          end
        end
        REQ: if (bus.resp_addr_ok) begin
          if (bus.resp_data_ok) begin
            state <= DONE;
            if (ld_q) rdata <= load_ext(bus.resp_data, bus.req_addr[2:0], bus.req_size, sx_q);
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (bus.resp_data_ok) begin
          state <= DONE;
          if (ld_q) rdata <= load_ext(bus.resp_data, bus.req_addr[2:0], bus.req_size, sx_q);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_access.sv
// Randomized bench for dram_access against a byte-arithmetic reference model.
module tb_dram_access;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ram_we = 1'b0;
  logic [3:0]  dram_sel = 4'd0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        busy, done, misalign;
  logic [63:0] rdata;

  dram_access_if bus ();

  dram_access dut (
    .clk(clk), .reset(reset), .start(start), .ram_we(ram_we), .dram_sel(dram_sel),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .misalign(misalign),
    .rdata(rdata), .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] rdata_exp = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: access width in bytes from the code, then plain shifts and masks.
  function automatic void model(input logic [3:0] sel, input logic we, input logic [63:0] a,
                                input logic [63:0] wd, input logic [63:0] rd,
                                output bit legal, output bit is_ld, output logic [2:0] size,
                                output logic [7:0] strb, output logic [63:0] wdat,
                                output logic [63:0] ld_val);
    int nb, off;
    bit sgn;
    logic [63:0] mask, v;
    off = int'(a[2:0]); nb = 0; sgn = 0; is_ld = 0;
    if (sel >= 1 && sel <= 7) begin nb = 1 << ((int'(sel) - 1) / 2); sgn = (sel % 2) == 1; is_ld = 1; end
    else if (sel >= 8 && sel <= 11) nb = 1 << (int'(sel) - 8);
    legal = (nb != 0) && (we == !is_ld) && ((off % (nb == 0 ? 1 : nb)) == 0);
    size  = (nb == 8) ? 3 : (nb == 4) ? 2 : (nb == 2) ? 1 : 0;
    strb  = is_ld ? 8'h00 : 8'(((1 << nb) - 1) << off);
    wdat  = wd << (8 * off);
    v     = rd >> (8 * off);
    mask  = (nb == 8) ? '1 : (64'd1 << (8 * nb)) - 64'd1;
    v     = v & mask;
    if (sgn && nb < 8 && nb > 0 && v[8 * nb - 1]) v = v | ~mask;
    ld_val = v;
  endfunction

  // d1: REQ cycles before addr_ok; w: WAIT cycles (data_ok in the last one, 0 = with addr_ok).
  task automatic access(input logic [3:0] sel, input logic we, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] rd,
                        input int d1, input int w, input bit hold_start);
    bit legal, ld;
    logic [2:0] sz;
    logic [7:0] sb;
    logic [63:0] wq, lv;
    model(sel, we, a, wd, rd, legal, ld, sz, sb, wq, lv);
    @(negedge clk);
    start = 1'b1; dram_sel = sel; ram_we = we; addr = a; wdata = wd; bus.resp_data = rd;
    @(posedge clk); #1;
    start = hold_start;
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    if (!legal) begin
      chk("mis_done", done, 1); chk("mis_flag", misalign, 1);
      chk("mis_req_valid", bus.req_valid, 0); chk("mis_busy", busy, 1);
      @(posedge clk); #1;
      start = 1'b0;
      chk("mis_idle_busy", busy, 0); chk("mis_idle_done", done, 0);
      chk("mis_rdata", rdata, rdata_exp);
      return;
    end
    for (int k = 0; k <= d1; k++) begin
      bus.resp_addr_ok = (k == d1);
      bus.resp_data_ok = (k == d1) && (w == 0);
      chk("req_valid", bus.req_valid, 1); chk("req_addr", bus.req_addr, a);
      chk("req_size", bus.req_size, sz); chk("req_strobe", bus.req_strobe, sb);
      if (!ld) chk("req_data", bus.req_data, wq);
      chk("req_done", done, 0); chk("req_busy", busy, 1);
      @(posedge clk); #1;
    end
    bus.resp_addr_ok = 1'b0; bus.resp_data_ok = 1'b0;
    for (int k = 1; k <= w; k++) begin
      bus.resp_data_ok = (k == w);
      chk("wait_req_valid", bus.req_valid, 0); chk("wait_busy", busy, 1); chk("wait_done", done, 0);
      @(posedge clk); #1;
    end
    bus.resp_data_ok = 1'b0;
    start = 1'b0;
    if (ld) rdata_exp = lv;
    chk("done", done, 1); chk("done_misalign", misalign, 0); chk("done_busy", busy, 1);
    chk("done_rdata", rdata, rdata_exp); chk("done_req_valid", bus.req_valid, 0);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0); chk("idle_done", done, 0); chk("idle_req_valid", bus.req_valid, 0);
  endtask

  initial begin
    bus.resp_addr_ok = 1'b0; bus.resp_data_ok = 1'b0; bus.resp_data = '0;
    #2;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_misalign", misalign, 0);
    chk("rst_rdata", rdata, 0); chk("rst_req_valid", bus.req_valid, 0);
    chk("rst_req_addr", bus.req_addr, 0); chk("rst_req_size", bus.req_size, 0);
    chk("rst_req_strobe", bus.req_strobe, 0); chk("rst_req_data", bus.req_data, 0);
    @(negedge clk); reset = 1'b1;

    access(4'd1, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0);
    chk("lb_value", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    access(4'd2, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0);
    chk("lbu_value", rdata, 64'h80);
    access(4'd9, 1'b1, 64'h2006, 64'hABCD_1234, 64'h0, 0, 0, 0);
    chk("sh_keeps_rdata", rdata, 64'h80);
    access(4'd5, 1'b0, 64'h3002, 64'h0, 64'h0, 0, 0, 0);
    access(4'd7, 1'b0, 64'h4000, 64'h0, 64'h1122_3344_5566_7788, 3, 2, 0);
    chk("ld_value", rdata, 64'h1122_3344_5566_7788);

    // Reset in the middle of WAIT abandons the access.
    @(negedge clk);
    start = 1'b1; dram_sel = 4'd7; ram_we = 1'b0; addr = 64'h4008; bus.resp_data = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    start = 1'b0; bus.resp_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.resp_addr_ok = 1'b0;
    chk("pre_rst_wait_busy", busy, 1);
    reset = 1'b0;
    #1;
    rdata_exp = '0;
    chk("arst_busy", busy, 0); chk("arst_req_valid", bus.req_valid, 0);
    chk("arst_rdata", rdata, 0); chk("arst_done", done, 0); chk("arst_req_addr", bus.req_addr, 0);
    @(negedge clk); reset = 1'b1;
    bus.resp_data_ok = 1'b1;
    @(posedge clk); #1;
    bus.resp_data_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_done", done, 0); chk("post_rst_busy", busy, 0);
      @(posedge clk); #1;
    end

    access(4'd5, 1'b0, 64'h5004, 64'h0, 64'h8765_4321_0000_0000, 2, 1, 1);

    for (int i = 0; i < 80; i++) begin
      logic [3:0]  sel;
      logic        we;
      logic [63:0] a;
      int          mode;
      sel  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
      we   = (sel >= 8);
      if ($urandom_range(0, 9) == 0) we = ~we;
      a    = {$urandom, $urandom};
      mode = $urandom_range(0, 2);
      if (mode == 1) a[0] = 1'b0;
      if (mode == 2) a[2:0] = 3'd0;
      access(sel, we, a, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
